// File: rtl/cp0_except_pkg.sv
// Shared definitions for the CP0 register file / exception resolver.
// Holds the CP0 register addresses, the exception codes handed to the
// pipeline controller, the Status/Cause field positions, the bit positions
// of the MEM-stage exception flag word, and a helper that maps an exception
// code onto the Cause.ExcCode value committed for it.
package cp0_except_pkg;

    // CP0 register addresses
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    // Exception codes presented to the controller
    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_SYS     = 32'h8;
    localparam logic [31:0] EXC_INV     = 32'ha;
    localparam logic [31:0] EXC_OVF     = 32'hc;
    localparam logic [31:0] EXC_TRAP    = 32'hd;
    localparam logic [31:0] EXC_ERET    = 32'he;
    localparam logic [31:0] EXC_TLBMISS = 32'hf;

    // Status fields
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // Cause fields
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_SWIP_HI = 9;
    localparam int CA_BD     = 31;

    // mem_excflags_i bit positions
    localparam int FL_SYSCALL = 8;
    localparam int FL_INVALID = 9;
    localparam int FL_TRAP    = 10;
    localparam int FL_OVF     = 11;
    localparam int FL_ERET    = 12;
    localparam int FL_TLBMISS = 13;

    // Cause.ExcCode value recorded for each committed exception
    function automatic logic [4:0] exc_code(input logic [31:0] et);
        logic [4:0] code;
        code = 5'd0;
        case (et)
            EXC_INT:     code = 5'd0;
            EXC_TLBMISS: code = 5'd2;
            EXC_SYS:     code = 5'd8;
            EXC_INV:     code = 5'd10;
            EXC_TRAP:    code = 5'd13;
            EXC_OVF:     code = 5'd12;
            default:     code = 5'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_except_timer.sv
// Count/Compare timer for CP0.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   count_we_i        load Count from wdata_i instead of incrementing
//   compare_we_i      load Compare from wdata_i, clears the timer interrupt
//   wdata_i           write data shared by both registers
//   count_o           current Count
//   compare_o         current Compare
//   timer_int_o       sticky timer interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tint_q, tint_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
        tint_d    = tint_q;
        // A Compare write always wins, even against a match in the same cycle.
        if (compare_we_i) begin
            tint_d = 1'b0;
        end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            tint_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tint_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tint_q    <= tint_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_except.sv
// CP0 register file merged with MEM-stage exception resolution.
// Prioritises MEM exception flags and interrupts into one exception code for
// the pipeline controller, commits it into Status/Cause/EPC/BadVAddr on the
// next edge, and hosts the Count/Compare timer.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   int_i             hardware interrupt lines (Cause.IP[7:2])
//   raddr_i/rdata_o   mfc0 read port (combinational, WB-forwarded)
//   we_i/waddr_i/wdata_i  mtc0 write port from WB
//   mem_excflags_i, mem_pc_i, mem_in_delay_i, mem_badvaddr_i  MEM-stage info
//   excepttype_o      exception code for the controller
//   cp0_epc_o         forwarded EPC for eret
//   status_o/cause_o  forwarded Status/Cause
//   timer_int_o       sticky timer interrupt
module cp0_except
    import cp0_except_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h00004220,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_excflags_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic [31:0] mem_badvaddr_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count, compare;
    logic [31:0] status_fwd, cause_fwd, epc_fwd, count_fwd, compare_fwd;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        int_pending;
    logic        unused_flags;

    assign unused_flags = ^{mem_excflags_i[31:14], mem_excflags_i[7:0]};

    assign wr_count   = we_i && (waddr_i == CP0_COUNT);
    assign wr_compare = we_i && (waddr_i == CP0_COMPARE);
    assign wr_status  = we_i && (waddr_i == CP0_STATUS);
    assign wr_cause   = we_i && (waddr_i == CP0_CAUSE);
    assign wr_epc     = we_i && (waddr_i == CP0_EPC);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .wdata_i      (wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int_o)
    );

    // WB-forwarded views; only the software interrupt bits of Cause are writable.
    always_comb begin
        status_fwd  = wr_status ? wdata_i : status_q;
        epc_fwd     = wr_epc ? wdata_i : epc_q;
        count_fwd   = wr_count ? wdata_i : count;
        compare_fwd = wr_compare ? wdata_i : compare;
        cause_fwd   = cause_q;
        if (wr_cause) begin
            cause_fwd[CA_SWIP_HI:CA_IP_LO] = wdata_i[CA_SWIP_HI:CA_IP_LO];
        end
    end

    assign int_pending = (|(cause_fwd[CA_IP_HI:CA_IP_LO] & status_fwd[ST_IM_HI:ST_IM_LO]))
                         && status_fwd[ST_IE] && !status_fwd[ST_EXL];

    always_comb begin
        excepttype_o = EXC_NONE;
        if (rst && (mem_pc_i != 32'd0)) begin
            if (int_pending)                      excepttype_o = EXC_INT;
            else if (mem_excflags_i[FL_TLBMISS])  excepttype_o = EXC_TLBMISS;
            else if (mem_excflags_i[FL_SYSCALL])  excepttype_o = EXC_SYS;
            else if (mem_excflags_i[FL_INVALID])  excepttype_o = EXC_INV;
            else if (mem_excflags_i[FL_TRAP])     excepttype_o = EXC_TRAP;
            else if (mem_excflags_i[FL_OVF])      excepttype_o = EXC_OVF;
            else if (mem_excflags_i[FL_ERET])     excepttype_o = EXC_ERET;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        if (rst) begin
            case (raddr_i)
                CP0_BADVADDR: rdata_o = badvaddr_q;
                CP0_COUNT:    rdata_o = count_fwd;
                CP0_COMPARE:  rdata_o = compare_fwd;
                CP0_STATUS:   rdata_o = status_fwd;
                CP0_CAUSE:    rdata_o = cause_fwd;
                CP0_EPC:      rdata_o = epc_fwd;
                CP0_PRID:     rdata_o = PRID_VALUE;
                CP0_CONFIG:   rdata_o = CONFIG_VALUE;
                default:      rdata_o = 32'd0;
            endcase
        end
    end

    // Next state starts from the forwarded (WB-written) values so that a
    // commit in the same cycle overlays its fields on top of the write.
    always_comb begin
        status_d   = status_fwd;
        cause_d    = cause_fwd;
        epc_d      = epc_fwd;
        badvaddr_d = badvaddr_q;
        cause_d[CA_IP_HI:CA_IP_LO+2] = {int_i[5] | timer_int_o, int_i[4:0]};
        if (excepttype_o == EXC_ERET) begin
            status_d[ST_EXL] = 1'b0;
        end else if (excepttype_o != EXC_NONE) begin
            // Nested exceptions keep the original return address and BD.
            if (!status_fwd[ST_EXL]) begin
                epc_d         = mem_in_delay_i ? mem_pc_i - 32'd4 : mem_pc_i;
                cause_d[CA_BD] = mem_in_delay_i;
            end
            status_d[ST_EXL]              = 1'b1;
            cause_d[CA_EXC_HI:CA_EXC_LO]  = exc_code(excepttype_o);
            if (excepttype_o == EXC_TLBMISS) begin
                badvaddr_d = mem_badvaddr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign cp0_epc_o = epc_fwd;
    assign status_o  = status_fwd;
    assign cause_o   = cause_fwd;

endmodule

// File: tb/tb_cp0_except.sv
// Self-checking bench for cp0_except: directed scenarios followed by
// randomized traffic compared every cycle against a register-array model.
module tb_cp0_except;

    localparam logic [31:0] PRID   = 32'h00004220;
    localparam logic [31:0] CONFIG = 32'h00008000;
    localparam logic [31:0] ST_RST = 32'h10000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic [4:0]  raddr;
    logic [31:0] rdata_o;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] flags;
    logic [31:0] pc;
    logic        delay;
    logic [31:0] badv;
    logic [31:0] excepttype_o;
    logic [31:0] cp0_epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic        timer_int_o;

    always #10 clk = ~clk;

    cp0_except dut (
        .clk            (clk),
        .rst            (rst),
        .int_i          (int_i),
        .raddr_i        (raddr),
        .rdata_o        (rdata_o),
        .we_i           (we),
        .waddr_i        (waddr),
        .wdata_i        (wdata),
        .mem_excflags_i (flags),
        .mem_pc_i       (pc),
        .mem_in_delay_i (delay),
        .mem_badvaddr_i (badv),
        .excepttype_o   (excepttype_o),
        .cp0_epc_o      (cp0_epc_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .timer_int_o    (timer_int_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: CP0 registers kept in an array indexed by address.
    logic [31:0] m_reg [0:31];
    logic        m_tint;

    function automatic logic writable(input logic [4:0] a);
        return a inside {5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a);
        if (we && waddr == a && writable(a)) begin
            if (a == 5'd13) return {m_reg[13][31:10], wdata[9:8], m_reg[13][7:0]};
            return wdata;
        end
        return m_reg[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_reg[12] = ST_RST;
        m_reg[15] = PRID;
        m_reg[16] = CONFIG;
        m_tint    = 1'b0;
    endtask

    function automatic logic [31:0] exp_exc();
        logic [31:0] sf, cf;
        if (!rst || pc == 32'd0) return 32'h0;
        sf = fwd(5'd12);
        cf = fwd(5'd13);
        if ((cf[15:8] & sf[15:8]) != 8'd0 && sf[0] && !sf[1]) return 32'h1;
        if (flags[13]) return 32'hf;
        if (flags[8])  return 32'h8;
        if (flags[9])  return 32'ha;
        if (flags[10]) return 32'hd;
        if (flags[11]) return 32'hc;
        if (flags[12]) return 32'he;
        return 32'h0;
    endfunction

    function automatic logic [4:0] code_of(input logic [31:0] e);
        case (e)
            32'h1:   return 5'd0;
            32'hf:   return 5'd2;
            32'h8:   return 5'd8;
            32'ha:   return 5'd10;
            32'hd:   return 5'd13;
            32'hc:   return 5'd12;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!rst) return 32'd0;
        if (raddr inside {5'd8, 5'd15, 5'd16}) return m_reg[raddr];
        if (writable(raddr)) return fwd(raddr);
        return 32'd0;
    endfunction

    task automatic check_model();
        chk("excepttype", excepttype_o, exp_exc());
        chk("rdata", rdata_o, exp_rdata());
        chk("epc", cp0_epc_o, fwd(5'd14));
        chk("status", status_o, fwd(5'd12));
        chk("cause", cause_o, fwd(5'd13));
        chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
    endtask

    task automatic update_model();
        logic [31:0] e, sf, cf, ef;
        logic        tint_old;
        if (!rst) begin
            m_reset();
            return;
        end
        e  = exp_exc();
        sf = fwd(5'd12);
        cf = fwd(5'd13);
        ef = fwd(5'd14);
        tint_old = m_tint;
        if (we && waddr == 5'd11) m_tint = 1'b0;
        else if (m_reg[11] != 32'd0 && m_reg[9] == m_reg[11]) m_tint = 1'b1;
        m_reg[11] = fwd(5'd11);
        m_reg[9]  = (we && waddr == 5'd9) ? wdata : m_reg[9] + 32'd1;
        cf[15:10] = {int_i[5] | tint_old, int_i[4:0]};
        if (e == 32'he) begin
            sf[1] = 1'b0;
        end else if (e != 32'h0) begin
            if (!sf[1]) begin
                ef     = delay ? pc - 32'd4 : pc;
                cf[31] = delay;
            end
            sf[1]   = 1'b1;
            cf[6:2] = code_of(e);
            if (e == 32'hf) m_reg[8] = badv;
        end
        m_reg[12] = sf;
        m_reg[13] = cf;
        m_reg[14] = ef;
    endtask

    task automatic cycle();
        #2;
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 5'd0;
        flags = 32'd0; pc = 32'd0; delay = 1'b0; badv = 32'd0; int_i = 6'd0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    logic [4:0] addrs [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    int rise;

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk);
        m_reset();
        #1;

        // Reset state
        raddr = 5'd15;
        #1;
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_status", status_o, ST_RST);
        chk("rst_epc", cp0_epc_o, 32'd0);
        cycle();
        rst = 1'b1;
        cycle();

        // Timer: rise 10 cycles after the Compare write lands, clear on rewrite
        wr(5'd11, m_reg[9] + 32'd10);
        rise = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (timer_int_o === 1'b1 && rise < 0) rise = k;
        end
        chk("timer_rise", rise, 10);
        wr(5'd11, 32'd0);
        chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
        wr(5'd9, 32'hffff_fffe);
        raddr = 5'd9;
        cycle();
        chk("count_ff", rdata_o, 32'hffff_ffff);
        cycle();
        chk("count_wrap", rdata_o, 32'd0);

        // Syscall
        idle();
        flags = 32'h100; pc = 32'h8000_0100;
        #1;
        chk("sys_type", excepttype_o, 32'h8);
        cycle();
        idle();
        #1;
        chk("sys_epc", cp0_epc_o, 32'h8000_0100);
        chk("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
        chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
        chk("sys_bd", {31'd0, cause_o[31]}, 32'd0);

        // Overflow in a delay slot
        wr(5'd12, ST_RST);
        flags = 32'h800; pc = 32'h8000_0204; delay = 1'b1;
        #1;
        chk("ovf_type", excepttype_o, 32'hc);
        cycle();
        idle();
        #1;
        chk("ovf_epc", cp0_epc_o, 32'h8000_0200);
        chk("ovf_bd", {31'd0, cause_o[31]}, 32'd1);

        // ERET with a same-cycle EPC write
        flags = 32'h1000; pc = 32'h8000_0300;
        we = 1'b1; waddr = 5'd14; wdata = 32'h8000_1000;
        #1;
        chk("eret_type", excepttype_o, 32'he);
        chk("eret_epc_fwd", cp0_epc_o, 32'h8000_1000);
        cycle();
        idle();
        #1;
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
        chk("eret_epc", cp0_epc_o, 32'h8000_1000);

        // Interrupt beats syscall; masked once EXL is set
        int_i = 6'd1;
        wr(5'd12, 32'h1000_0401);
        flags = 32'h100; pc = 32'h8000_0400;
        #1;
        chk("int_type", excepttype_o, 32'h1);
        cycle();
        #1;
        chk("int_code", {27'd0, cause_o[6:2]}, 32'd0);
        chk("int_exl_type", excepttype_o, 32'h8);
        cycle();
        idle();
        wr(5'd12, ST_RST);

        // Bubble
        flags = 32'h100; pc = 32'd0;
        #1;
        chk("bubble_type", excepttype_o, 32'h0);
        cycle();

        // Reset during a syscall commit
        flags = 32'h100; pc = 32'h8000_0500; rst = 1'b0;
        #1;
        chk("rstc_type", excepttype_o, 32'h0);
        cycle();
        idle();
        #1;
        chk("rstc_status", status_o, ST_RST);
        chk("rstc_cause", cause_o, 32'd0);
        chk("rstc_epc", cp0_epc_o, 32'd0);
        chk("rstc_tint", {31'd0, timer_int_o}, 32'd0);
        rst = 1'b1; raddr = 5'd9;
        #1;
        chk("rstc_count", rdata_o, 32'd0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) != 0);
            we    = ($urandom_range(0, 3) == 0);
            waddr = addrs[$urandom_range(0, 8)];
            wdata = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1)
                wdata = m_reg[9] + 32'($urandom_range(1, 4));
            raddr = addrs[$urandom_range(0, 8)];
            flags = (($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_3f00) : 32'd0)
                    | ($urandom & 32'hffff_c0ff);
            pc    = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'hffff_fffc);
            delay = 1'($urandom_range(0, 1));
            int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            badv  = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
